mem_access_ctrl: RTL and testbench

Memory access controller that sits directly downstream of the MAR mux and the system bus. It holds the MAR and MDR registers and runs a single-outstanding request/acknowledge handshake to data memory. It reports completion to the control FSM through a one-cycle ready strobe `R`, in the LC-3 style where the FSM waits while `!R`. A timeout bounds every access and raises a sticky error flag.

---
 rtl/mem_access_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MAR/MDR holder and single-outstanding memory handshake controller.
// Completion is signalled by a one-cycle R strobe; a per-access timeout sets a sticky error.
module mem_access_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Bus,
    input  logic              ldMAR,
    input  logic              ldMDR,
    input  logic              memEN,
    input  logic              memWE,
    output logic [ADDR_W-1:0] MAROut,
    output logic [DATA_W-1:0] MDROut,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDataOut,
    input  logic [DATA_W-1:0] memDataIn,
    output logic              memReq,
    output logic              memWr,
    input  logic              memAck,
    output logic              R,
    output logic              busy,
    output logic              memErr
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state, stateNext;
    logic [ADDR_W-1:0]  mar, marNext, pendMar, pendMarNext;
    logic [DATA_W-1:0]  mdr, mdrNext, pendMdr, pendMdrNext;
    logic               pendMarVld, pendMarVldNext, pendMdrVld, pendMdrVldNext;
    logic [CNT_W-1:0]   waitCnt, cntNext;
    logic               wrReg, wrNext, errReg, errNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mar        <= '0;
            mdr        <= '0;
            pendMar    <= '0;
            pendMdr    <= '0;
            pendMarVld <= 1'b0;
            pendMdrVld <= 1'b0;
            waitCnt    <= '0;
            wrReg      <= 1'b0;
            errReg     <= 1'b0;
        end else begin
            state      <= stateNext;
            mar        <= marNext;
            mdr        <= mdrNext;
            pendMar    <= pendMarNext;
            pendMdr    <= pendMdrNext;
            pendMarVld <= pendMarVldNext;
            pendMdrVld <= pendMdrVldNext;
            waitCnt    <= cntNext;
            wrReg      <= wrNext;
            errReg     <= errNext;
        end
    end

    always_comb begin
        stateNext      = state;
        marNext        = mar;
        mdrNext        = mdr;
        pendMarNext    = pendMar;
        pendMdrNext    = pendMdr;
        pendMarVldNext = pendMarVld;
        pendMdrVldNext = pendMdrVld;
        cntNext        = waitCnt;
        wrNext         = wrReg;
        errNext        = errReg;
        case (state)
            IDLE: begin
                if (ldMAR) marNext = Bus[ADDR_W-1:0];
                if (ldMDR) mdrNext = Bus;
                if (memEN) begin
                    // Loads coinciding with a start are parked and applied once the access retires,
                    // so the access sees the pre-edge MAR (and MDR for writes).
                    marNext   = mar;
                    wrNext    = memWE;
                    cntNext   = '0;
                    stateNext = REQ;
                    if (ldMAR) begin
                        pendMarNext    = Bus[ADDR_W-1:0];
                        pendMarVldNext = 1'b1;
                    end
                    if (ldMDR && memWE) begin
                        mdrNext        = mdr;
                        pendMdrNext    = Bus;
                        pendMdrVldNext = 1'b1;
                    end
                end
            end
            REQ: begin
                if (memAck) begin
                    if (!wrReg) mdrNext = memDataIn;
                    stateNext = DONE;
                end else if (waitCnt == LAST) begin
                    errNext   = 1'b1;
                    stateNext = DONE;
                end else begin
                    cntNext = waitCnt + CNT_W'(1);
                end
            end
            DONE: begin
                stateNext = IDLE;
                if (pendMarVld) marNext = pendMar;
                if (pendMdrVld) mdrNext = pendMdr;
                pendMarVldNext = 1'b0;
                pendMdrVldNext = 1'b0;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign MAROut     = mar;
    assign MDROut     = mdr;
    assign memAddr    = mar;
    assign memDataOut = mdr;
    assign memReq     = (state == REQ);
    assign R          = (state == DONE);
    assign busy       = (state != IDLE);
    assign memWr      = wrReg;
    assign memErr     = errReg;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: reset, reads, writes, locking, timeout, reset mid-access.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Bus, MAROut, MDROut, memAddr, memDataOut, memDataIn;
    logic        ldMAR, ldMDR, memEN, memWE, memReq, memWr, memAck, R, busy, memErr;
    int          checks = 0;
    int          failures = 0;
    int          reqCycles;

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .Bus(Bus), .ldMAR(ldMAR), .ldMDR(ldMDR),
        .memEN(memEN), .memWE(memWE), .MAROut(MAROut), .MDROut(MDROut),
        .memAddr(memAddr), .memDataOut(memDataOut), .memDataIn(memDataIn),
        .memReq(memReq), .memWr(memWr), .memAck(memAck), .R(R),
        .busy(busy), .memErr(memErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        Bus = 16'($urandom); ldMAR = 1'b1; ldMDR = 1'b1; memEN = 1'b1; memWE = 1'b1;
        memAck = 1'b1; memDataIn = 16'($urandom);
        tick();
        Bus = 16'($urandom); memDataIn = 16'($urandom);
        tick();
        chk("rst_MAR", MAROut, 0);
        chk("rst_MDR", MDROut, 0);
        chk("rst_req", memReq, 0);
        chk("rst_wr", memWr, 0);
        chk("rst_R", R, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", memErr, 0);

        rst = 1'b0; ldMDR = 1'b0; memEN = 1'b0; memWE = 1'b0; memAck = 1'b0; memDataIn = '0;
        ldMAR = 1'b1; Bus = 16'h3000;
        tick();
        ldMAR = 1'b0;
        chk("ld_MAR", MAROut, 16'h3000);

        // read, ack in third REQ cycle
        memEN = 1'b1; memWE = 1'b0;
        tick();
        memEN = 1'b0;
        chk("rd_req1", memReq, 1);
        chk("rd_addr", memAddr, 16'h3000);
        chk("rd_wr", memWr, 0);
        tick();
        chk("rd_req2", memReq, 1);
        tick();
        chk("rd_req3", memReq, 1);
        chk("rd_noR", R, 0);
        memAck = 1'b1; memDataIn = 16'hBEEF;
        tick();
        memAck = 1'b0;
        chk("rd_R", R, 1);
        chk("rd_reqlow", memReq, 0);
        chk("rd_MDR", MDROut, 16'hBEEF);
        chk("rd_err", memErr, 0);
        tick();
        chk("rd_Rpulse", R, 0);
        chk("rd_idle", busy, 0);

        // write with immediate ack; ack already high in IDLE must be ignored
        ldMDR = 1'b1; Bus = 16'h1234;
        tick();
        ldMDR = 1'b0; ldMAR = 1'b1; Bus = 16'h4000;
        tick();
        ldMAR = 1'b0;
        chk("wr_MDRld", MDROut, 16'h1234);
        memEN = 1'b1; memWE = 1'b1; memAck = 1'b1; memDataIn = 16'hFFFF;
        tick();
        memEN = 1'b0; memWE = 1'b0;
        chk("wr_req", memReq, 1);
        chk("wr_wr", memWr, 1);
        chk("wr_addr", memAddr, 16'h4000);
        chk("wr_data", memDataOut, 16'h1234);
        tick();
        memAck = 1'b0;
        chk("wr_R", R, 1);
        chk("wr_MDRkeep", MDROut, 16'h1234);
        tick();

        // loads during REQ are ignored
        memEN = 1'b1;
        tick();
        memEN = 1'b0; ldMAR = 1'b1; ldMDR = 1'b1; Bus = 16'h5555;
        tick();
        chk("lk_addr", memAddr, 16'h4000);
        memAck = 1'b1; memDataIn = 16'h1111;
        tick();
        memAck = 1'b0;
        chk("lk_MDR", MDROut, 16'h1111);
        tick();
        ldMAR = 1'b0; ldMDR = 1'b0;
        chk("lk_MAR", MAROut, 16'h4000);
        chk("lk_MDRafter", MDROut, 16'h1111);

        // ldMAR together with memEN: access uses old MAR
        ldMAR = 1'b1; Bus = 16'h6000; memEN = 1'b1; memWE = 1'b0;
        tick();
        ldMAR = 1'b0; memEN = 1'b0;
        chk("sc_addr", memAddr, 16'h4000);
        memAck = 1'b1; memDataIn = 16'h2468;
        tick();
        memAck = 1'b0;
        chk("sc_R", R, 1);
        tick();
        chk("sc_MAR", MAROut, 16'h6000);

        // ack in the last permitted REQ cycle is a success
        memEN = 1'b1;
        tick();
        memEN = 1'b0;
        repeat (14) tick();
        chk("lw_req15", memReq, 1);
        memAck = 1'b1; memDataIn = 16'h7777;
        tick();
        memAck = 1'b0;
        chk("lw_R", R, 1);
        chk("lw_err", memErr, 0);
        chk("lw_MDR", MDROut, 16'h7777);
        tick();

        // timeout
        memEN = 1'b1;
        tick();
        memEN = 1'b0;
        reqCycles = 0;
        while (memReq === 1'b1 && reqCycles < 40) begin
            reqCycles++;
            tick();
        end
        chk("to_cycles", reqCycles, 15);
        chk("to_R", R, 1);
        chk("to_err", memErr, 1);
        chk("to_MDR", MDROut, 16'h7777);
        tick();
        memEN = 1'b1;
        tick();
        memEN = 1'b0; memAck = 1'b1; memDataIn = 16'h2222;
        tick();
        memAck = 1'b0;
        chk("to_nextR", R, 1);
        chk("to_nextMDR", MDROut, 16'h2222);
        chk("to_sticky", memErr, 1);
        tick();

        // reset mid-access beats a simultaneous ack
        memEN = 1'b1;
        tick();
        memEN = 1'b0;
        chk("mr_req", memReq, 1);
        rst = 1'b1; memAck = 1'b1; memDataIn = 16'hAAAA;
        tick();
        rst = 1'b0; memAck = 1'b0;
        chk("mr_req0", memReq, 0);
        chk("mr_busy", busy, 0);
        chk("mr_R", R, 0);
        chk("mr_MDR", MDROut, 0);
        chk("mr_err", memErr, 0);
        tick();
        chk("mr_Rlater", R, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
